i_type_issue: RTL



---
 rtl/isa_pkg.sv | 31 +++
 rtl/i_type_issue.sv | 107 ++++++++++
 2 files changed

// File: rtl/isa_pkg.sv
// Shared I-type ISA definitions: opcodes, field slices and the issue FSM state encoding.
// Imported by the issue sequencer and by anything that decodes I-type words.
package isa_pkg;

  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd10;
  localparam logic [5:0] OP_ORI   = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EX   = 2'd2,
    WB   = 2'd3
  } state_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op >= OP_ADDI) && (op <= OP_SLTI);
  endfunction

endpackage

// File: rtl/i_type_issue.sv
// I-type issue/writeback sequencer: accept, read rs, drive I_ALU, write rt; 4 cycles per instruction.
// Latency accept->rf_we is 3 edges; in_ready is low while an instruction is in flight (producer holds in_valid).
module i_type_issue
  import isa_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RF_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  output logic [RF_AW-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [31:0]       alu_inst,
  output logic [DATA_W-1:0] alu_op1,
  output logic [15:0]       alu_imm,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              illegal
);

  state_e            state_q, state_d;
  logic [31:0]       inst_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] res_q;
  logic              we_q;
  logic              illegal_q;

  logic              accept;
  logic              legal_in;
  logic [4:0]        rs_f;
  logic [4:0]        rt_f;

  assign accept   = in_valid && in_ready;
  assign legal_in = is_legal_op(in_inst[OPC_HI:OPC_LO]);
  assign rs_f     = inst_q[RS_HI:RS_LO];
  assign rt_f     = inst_q[RT_HI:RT_LO];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && legal_in) state_d = RD;
      RD:   state_d = EX;
      EX:   state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state_q == IDLE) && !rst;
    busy     = (state_q != IDLE);
    rf_raddr = RF_AW'(rs_f);
    alu_inst = inst_q;
    alu_imm  = inst_q[IMM_HI:IMM_LO];
    // In EX the ALU must see the freshly read operand, not the stale capture.
    alu_op1  = (state_q == EX) ? rf_rdata : op1_q;
    rf_waddr = RF_AW'(rt_f);
    rf_wdata = res_q;
    rf_we    = we_q && !rst;
    illegal  = illegal_q && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q    <= '0;
      op1_q     <= '0;
      res_q     <= '0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !legal_in;
      // r0 is hardwired: the WB slot still happens but never writes it.
      we_q      <= (state_q == EX) && (rt_f != 5'd0);
      if (accept) begin
        inst_q <= in_inst;
      end
      if (state_q == EX) begin
        op1_q <= rf_rdata;
        res_q <= alu_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rf_we && illegal)) else $error("rf_we and illegal asserted together");
    end
  end

endmodule
